// File: rtl/hwdata_beat_sequencer_if.sv
// ---------------------------------------------------------------------------
// hwdata_beat_sequencer_if
//
// Purpose: bundles the request handshake and APB signals of the
// hwdata_beat_sequencer so the block and its environment share one port.
//
// Signals:
//   start, start_addr      - request to split one AHB write into APB beats
//   PREADY, PSLVERR        - APB slave response
//   sel                    - beat index for the write-data slice mux
//   PSEL, PENABLE, PWRITE  - APB control
//   PADDR                  - APB address of the current beat
//   ready, done, err       - sequencer status
//
// Modports:
//   master - environment side (requester plus APB slave response)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface hwdata_beat_sequencer_if #(
    parameter int AW       = 32,
    parameter int logRATIO = 2
);
    logic                start;
    logic [AW-1:0]       start_addr;
    logic                PREADY;
    logic                PSLVERR;
    logic [logRATIO-1:0] sel;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [AW-1:0]       PADDR;
    logic                ready;
    logic                done;
    logic                err;

    modport master (
        output start, start_addr, PREADY, PSLVERR,
        input  sel, PSEL, PENABLE, PWRITE, PADDR, ready, done, err
    );

    modport slave (
        input  start, start_addr, PREADY, PSLVERR,
        output sel, PSEL, PENABLE, PWRITE, PADDR, ready, done, err
    );
endinterface

// File: rtl/hwdata_beat_sequencer.sv
// ---------------------------------------------------------------------------
// hwdata_beat_sequencer
//
// Purpose: splits one AHB write of AHB_DW bits into RATIO consecutive APB
// write beats of APB_DW bits each. For every beat it runs an APB SETUP and
// ACCESS phase, steps the beat index (sel) that drives the write-data slice
// mux, and advances PADDR by one APB word. An APB slave error aborts the
// remaining beats and is reported alongside the done pulse.
//
// Ports:
//   HCLK    - clock, all state changes on the rising edge
//   HRESET  - synchronous active-high reset
//   bus     - hwdata_beat_sequencer_if.slave
//             in : start, start_addr, PREADY, PSLVERR
//             out: sel, PSEL, PENABLE, PWRITE, PADDR, ready, done, err
//
// Every output is either a register or a decode of the registered state, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module hwdata_beat_sequencer #(
    parameter int AHB_DW   = 32,
    parameter int APB_DW   = 8,
    parameter int RATIO    = 4,
    parameter int logRATIO = 2,
    parameter int AW       = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    hwdata_beat_sequencer_if.slave  bus
);

    // State encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // The AHB word address is aligned to the AHB data width, so its low
    // byte-offset bits are cleared when the request is accepted.
    localparam int            ALIGN_BITS = $clog2(AHB_DW / 8);
    localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << ALIGN_BITS) - AW'(1));

    // Each beat moves the APB address forward by one APB word (in bytes).
    localparam logic [AW-1:0] ADDR_STEP = AW'(APB_DW / 8);

    // Index of the final beat of a sequence.
    localparam logic [logRATIO-1:0] LAST_SEL = logRATIO'(RATIO - 1);

    logic [1:0]          r_state;
    logic [AW-1:0]       r_paddr;
    logic [logRATIO-1:0] r_sel;
    logic                r_err;

    logic                w_inBeat;
    logic                w_lastBeat;

    assign w_inBeat   = (r_state == SETUP) || (r_state == ACCESS);
    assign w_lastBeat = (r_sel == LAST_SEL);

    // Main sequencer: reset wins over everything, including a sequence in
    // flight, so an aborted sequence never reaches DONE. Outside IDLE the
    // start request is simply not looked at, which gives "no queueing".
    // err is cleared on the way back to IDLE so that IDLE always shows the
    // reset value; it is only meaningful together with done.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE;
            r_paddr <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_paddr <= bus.start_addr & ALIGN_MASK;
                        r_sel   <= '0;
                        r_err   <= 1'b0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        if (bus.PSLVERR) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else if (w_lastBeat) begin
                            r_state <= DONE;
                        end else begin
                            r_sel   <= r_sel + logRATIO'(1);
                            r_paddr <= r_paddr + ADDR_STEP;
                            r_state <= SETUP;
                        end
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state. PSEL stays high across the
    // SETUP/ACCESS pair of a beat, PENABLE only rises in ACCESS, and PWRITE
    // follows PSEL because every transfer this block issues is a write.
    assign bus.PSEL    = w_inBeat;
    assign bus.PENABLE = (r_state == ACCESS);
    assign bus.PWRITE  = w_inBeat;
    assign bus.PADDR   = r_paddr;
    assign bus.sel     = r_sel;
    assign bus.ready   = (r_state == IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.err     = r_err;

endmodule

// File: tb/tb_hwdata_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hwdata_beat_sequencer
//
// Directed testbench for hwdata_beat_sequencer with default parameters
// (32-bit AHB, 8-bit APB, four beats per request, 32-bit addresses).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every check sees the state settled after that edge.
// ---------------------------------------------------------------------------
module tb_hwdata_beat_sequencer;

    logic HCLK;
    logic HRESET;

    int assertCount;
    int failCount;

    hwdata_beat_sequencer_if #(.AW(32), .logRATIO(2)) bus ();

    hwdata_beat_sequencer #(
        .AHB_DW   (32),
        .APB_DW   (8),
        .RATIO    (4),
        .logRATIO (2),
        .AW       (32)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    // Free-running clock, period 10
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one rising edge and step just past it
    task automatic applyStimulus();
        @(posedge HCLK);
        #1;
    endtask

    // Single comparison with an immediate assertion
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Compare every sequencer output against hand-computed values
    task automatic checkBus(input string tag, input logic psel, input logic pen,
                            input logic [31:0] paddr, input logic [1:0] sel,
                            input logic rdy, input logic dn, input logic er);
        checkOutput({tag, ".PSEL"},    32'(bus.PSEL),    32'(psel));
        checkOutput({tag, ".PENABLE"}, 32'(bus.PENABLE), 32'(pen));
        checkOutput({tag, ".PWRITE"},  32'(bus.PWRITE),  32'(psel));
        checkOutput({tag, ".PADDR"},   bus.PADDR,        paddr);
        checkOutput({tag, ".sel"},     32'(bus.sel),     32'(sel));
        checkOutput({tag, ".ready"},   32'(bus.ready),   32'(rdy));
        checkOutput({tag, ".done"},    32'(bus.done),    32'(dn));
        checkOutput({tag, ".err"},     32'(bus.err),     32'(er));
    endtask

    // One zero-wait beat: we are in its SETUP cycle; leaves us in the
    // cycle after its ACCESS phase.
    task automatic runBeat(input string tag, input logic [31:0] paddr, input logic [1:0] sel);
        checkBus({tag, ".setup"}, 1'b1, 1'b0, paddr, sel, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkBus({tag, ".access"}, 1'b1, 1'b1, paddr, sel, 1'b0, 1'b0, 1'b0);
        applyStimulus();
    endtask

    initial begin
        assertCount       = 0;
        failCount         = 0;
        HRESET            = 1'b1;
        bus.start         = 1'b0;
        bus.start_addr    = 32'h0;
        bus.PREADY        = 1'b1;
        bus.PSLVERR       = 1'b0;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkBus("reset", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        HRESET = 1'b0;
        applyStimulus();
        checkBus("idle0", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Zero-wait sequence with unaligned address (done at cycle 9)
        $display("[TB] basic four-beat sequence");
        bus.start      = 1'b1;
        bus.start_addr = 32'h1000_0003;
        applyStimulus();
        bus.start      = 1'b0;
        for (int b = 0; b < 4; b++)
            runBeat($sformatf("basic.b%0d", b), 32'h1000_0000 + 32'(b), 2'(b));
        checkBus("basic.done", 1'b0, 1'b0, 32'h1000_0003, 2'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkBus("basic.idle", 1'b0, 1'b0, 32'h1000_0003, 2'd3, 1'b1, 1'b0, 1'b0);

        // Three wait states in beat 2 (ACCESS held cycles 6..9, done at 12)
        $display("[TB] wait states in beat 2");
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        runBeat("wait.b0", 32'h1000_0000, 2'd0);
        runBeat("wait.b1", 32'h1000_0001, 2'd1);
        checkBus("wait.b2.setup", 1'b1, 1'b0, 32'h1000_0002, 2'd2, 1'b0, 1'b0, 1'b0);
        bus.PREADY = 1'b0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkBus($sformatf("wait.b2.access%0d", c), 1'b1, 1'b1, 32'h1000_0002, 2'd2,
                     1'b0, 1'b0, 1'b0);
        end
        bus.PREADY = 1'b1;
        applyStimulus();
        runBeat("wait.b3", 32'h1000_0003, 2'd3);
        checkBus("wait.done", 1'b0, 1'b0, 32'h1000_0003, 2'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkBus("wait.idle", 1'b0, 1'b0, 32'h1000_0003, 2'd3, 1'b1, 1'b0, 1'b0);

        // Slave error in beat 1 aborts the rest
        $display("[TB] slave error in beat 1");
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        runBeat("slverr.b0", 32'h1000_0000, 2'd0);
        checkBus("slverr.b1.setup", 1'b1, 1'b0, 32'h1000_0001, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.PSLVERR = 1'b1;
        applyStimulus();
        checkBus("slverr.b1.access", 1'b1, 1'b1, 32'h1000_0001, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        bus.PSLVERR = 1'b0;
        checkBus("slverr.done", 1'b0, 1'b0, 32'h1000_0001, 2'd1, 1'b0, 1'b1, 1'b1);
        applyStimulus();
        checkBus("slverr.idle", 1'b0, 1'b0, 32'h1000_0001, 2'd1, 1'b1, 1'b0, 1'b0);

        // start held high throughout: ignored until IDLE, address sampled on accept
        $display("[TB] start held high");
        bus.start      = 1'b1;
        bus.start_addr = 32'h2000_0010;
        applyStimulus();
        bus.start_addr = 32'h3000_0020;
        for (int b = 0; b < 4; b++)
            runBeat($sformatf("hold.b%0d", b), 32'h2000_0010 + 32'(b), 2'(b));
        checkBus("hold.done", 1'b0, 1'b0, 32'h2000_0013, 2'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkBus("hold.idle", 1'b0, 1'b0, 32'h2000_0013, 2'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        bus.start = 1'b0;
        for (int b = 0; b < 4; b++)
            runBeat($sformatf("hold2.b%0d", b), 32'h3000_0020 + 32'(b), 2'(b));
        checkBus("hold2.done", 1'b0, 1'b0, 32'h3000_0023, 2'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkBus("hold2.idle", 1'b0, 1'b0, 32'h3000_0023, 2'd3, 1'b1, 1'b0, 1'b0);

        // Reset during ACCESS of beat 2, with start also asserted
        $display("[TB] reset mid-sequence");
        bus.start      = 1'b1;
        bus.start_addr = 32'h1000_0003;
        applyStimulus();
        bus.start      = 1'b0;
        runBeat("rst.b0", 32'h1000_0000, 2'd0);
        runBeat("rst.b1", 32'h1000_0001, 2'd1);
        applyStimulus();
        checkBus("rst.b2.access", 1'b1, 1'b1, 32'h1000_0002, 2'd2, 1'b0, 1'b0, 1'b0);
        HRESET    = 1'b1;
        bus.start = 1'b1;
        applyStimulus();
        checkBus("rst.applied", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        checkBus("rst.overstart", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        HRESET    = 1'b0;
        applyStimulus();
        checkBus("rst.nodone", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Top-of-address-space request
        $display("[TB] top of address space");
        bus.start      = 1'b1;
        bus.start_addr = 32'hFFFF_FFFC;
        applyStimulus();
        bus.start      = 1'b0;
        for (int b = 0; b < 4; b++)
            runBeat($sformatf("top.b%0d", b), 32'hFFFF_FFFC + 32'(b), 2'(b));
        checkBus("top.done", 1'b0, 1'b0, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkBus("top.idle", 1'b0, 1'b0, 32'hFFFF_FFFF, 2'd3, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hwdata_beat_sequencer.md
HWDATA_BEAT_SEQUENCER -- requirements
Module: hwdata_beat_sequencer

Interface
REQ-001 Parameters SHALL be: AHB_DW, default 32, AHB write-data width; APB_DW, default 8, APB data width; RATIO, default 4, AHB_DW/APB_DW; logRATIO, default 2, log2(RATIO); AW, default 32, address width.
REQ-002 Port HCLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port HRESET  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port start  input  1  SHALL request one AHB write to be split into RATIO APB beats.
REQ-005 Port start_addr  input  AW  SHALL give the AHB word address; sampled only when start is accepted.
REQ-006 Port PREADY  input  1  SHALL be the APB slave ready.
REQ-007 Port PSLVERR  input  1  SHALL be the APB slave error, valid only with PREADY in ACCESS.
REQ-008 Port sel  output  logRATIO  SHALL be the beat index driving the write-data slice mux.
REQ-009 Ports PSEL, PENABLE, PWRITE  output  1 each  SHALL be the APB control signals.
REQ-010 Port PADDR  output  AW  SHALL be the APB address of the current beat.
REQ-011 Port ready  output  1  SHALL be high only in IDLE (start accepted).
REQ-012 Port done  output  1  SHALL pulse one cycle at end of a sequence.
REQ-013 Port err  output  1  SHALL be valid with done; high if the sequence was aborted by PSLVERR.

Function
REQ-014 FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-015 IDLE with start=1: latch start_addr with low log2(AHB_DW/8) bits forced to 0 into PADDR, sel<=0, err<=0, next SETUP.
REQ-016 IDLE with start=0: remain IDLE; outputs hold reset values except PADDR/sel hold last values.
REQ-017 SETUP: PSEL=1, PENABLE=0, PWRITE=1; unconditional next ACCESS after exactly one cycle.
REQ-018 ACCESS: PSEL=1, PENABLE=1, PWRITE=1; PADDR and sel stable; remain while PREADY=0 (unbounded wait states).
REQ-019 ACCESS, PREADY=1, PSLVERR=1: err<=1, remaining beats abandoned, next DONE.
REQ-020 ACCESS, PREADY=1, PSLVERR=0, sel==RATIO-1: next DONE.
REQ-021 ACCESS, PREADY=1, PSLVERR=0, sel<RATIO-1: sel<=sel+1, PADDR<=PADDR+APB_DW/8 (modulo 2^AW), next SETUP.
REQ-022 DONE: done=1, PSEL=0, PENABLE=0, err held; unconditional next IDLE after one cycle.
REQ-023 start outside IDLE SHALL be ignored (no queueing); start in DONE is ignored, sampled again in IDLE.
REQ-024 Zero-wait latency: start sampled at edge 0 -> done high in cycle 2*RATIO+1, ready high cycle 2*RATIO+2.
REQ-025 PSEL SHALL never deassert between SETUP and ACCESS of the same beat; PENABLE SHALL be low on the first cycle of every beat.
REQ-026 PWRITE SHALL be 1 whenever PSEL=1 and 0 otherwise.
REQ-027 sel SHALL never exceed RATIO-1; no wrap within a sequence.
REQ-028 All outputs SHALL be registered or decoded from registered state only (no combinational input-to-output path).

Reset
REQ-029 HRESET=1 at a clock edge SHALL force IDLE, sel=0, PADDR=0, err=0, PSEL=0, PENABLE=0, PWRITE=0, done=0, ready=1 next cycle.
REQ-030 Reset SHALL take priority over start and over a sequence in progress; an aborted sequence produces no done pulse.

Verification
REQ-031 Defaults, start_addr=0x1000_0003, PREADY=1 -> PADDR 0x1000_0000/01/02/03, sel 0..3, done at cycle 9, err=0.
REQ-032 PREADY low for 3 cycles in beat 2 -> ACCESS held 4 cycles, PADDR=0x1000_0002, sel=2 stable, done at cycle 12.
REQ-033 PSLVERR=1 with PREADY in beat 1 -> no SETUP for beat 2, done=1 with err=1, ready next cycle.
REQ-034 start pulsed every cycle during a sequence -> exactly one sequence, next accepted only when ready=1.
REQ-035 HRESET asserted during ACCESS of beat 2 -> next cycle PSEL=0, sel=0, ready=1, no done pulse.
REQ-036 start_addr=0xFFFF_FFFC -> PADDR 0xFFFF_FFFC..0xFFFF_FFFF, no overflow side effects.
